// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter that shares one multi-cycle ALU between two
//               requesters. Define ALU_ARB_ERR_CHECK_EN to reject opcodes 4..7
//               with ERR instead of issuing them to the ALU.
// Revision    : 1.0
// ============================================================================
module alu_arbiter #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       req0_i,
   input  logic       req1_i,
   input  logic [2:0] op0_i,
   input  logic [2:0] op1_i,
   input  logic [7:0] a0_i,
   input  logic [7:0] b0_i,
   input  logic [7:0] a1_i,
   input  logic [7:0] b1_i,
   output logic       gnt0_o,
   output logic       gnt1_o,
   output logic       done0_o,
   output logic       done1_o,
   output logic [7:0] result_out_o,
   output logic       zero_out_o,
   output logic       err_o,
   output logic [7:0] alu_data1_o,
   output logic [7:0] alu_data2_o,
   output logic [2:0] alu_select_o,
   input  logic [7:0] alu_result_i,
   input  logic       alu_zero_i
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [3:0] C_WAIT  = 4'(WAIT_CYCLES);

   logic [1:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       ptr_q, ptr_d;
   logic       owner_q, owner_d;
   logic [2:0] sel_q, sel_d;
   logic [7:0] data1_q, data1_d;
   logic [7:0] data2_q, data2_d;
   logic [7:0] result_q, result_d;
   logic       zero_q, zero_d;
   logic       gnt0_q, gnt0_d;
   logic       gnt1_q, gnt1_d;
   logic       done0_q, done0_d;
   logic       done1_q, done1_d;

   logic       w_any;
   logic       w_win1;
   logic       w_illegal;
   logic [2:0] w_op;
   logic [7:0] w_a;
   logic [7:0] w_b;

   // Requester 1 wins when it is the only one asking or when the pointer favours it.
   assign w_any  = req0_i | req1_i;
   assign w_win1 = req1_i & (~req0_i | ptr_q);
   assign w_op   = w_win1 ? op1_i : op0_i;
   assign w_a    = w_win1 ? a1_i  : a0_i;
   assign w_b    = w_win1 ? b1_i  : b0_i;

`ifdef ALU_ARB_ERR_CHECK_EN
   logic illegal_q;
   logic err_q;

   assign w_illegal = w_op[2];

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         illegal_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if ((state_q == ST_IDLE) && w_any) begin
            illegal_q <= w_illegal;
         end
         err_q <= (state_q == ST_DONE) && illegal_q;
      end
   end

   assign err_o = err_q;
`else
   assign w_illegal = 1'b0;
   assign err_o     = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      sel_d    = sel_q;
      data1_d  = data1_q;
      data2_d  = data2_q;
      result_d = result_q;
      zero_d   = zero_q;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      done0_d  = 1'b0;
      done1_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_any) begin
               owner_d = w_win1;
               gnt0_d  = ~w_win1;
               gnt1_d  = w_win1;
               data1_d = w_a;
               data2_d = w_b;
               if (w_illegal) begin
                  // Rejected opcode never reaches the ALU; the select lines keep their old value.
                  cnt_d   = 4'd0;
                  state_d = ST_DONE;
               end else begin
                  sel_d   = w_op;
                  cnt_d   = C_WAIT;
                  state_d = ST_BUSY;
               end
            end
         end

         ST_BUSY: begin
            if (cnt_q <= 4'd1) begin
               result_d = alu_result_i;
               zero_d   = alu_zero_i;
               cnt_d    = 4'd0;
               state_d  = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         ST_DONE: begin
            // The completion pulse is registered on the way out, so it lands one cycle after capture.
            done0_d = ~owner_q;
            done1_d = owner_q;
            ptr_d   = ~owner_q;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         ptr_q    <= 1'b0;
         owner_q  <= 1'b0;
         sel_q    <= 3'd0;
         data1_q  <= 8'd0;
         data2_q  <= 8'd0;
         result_q <= 8'd0;
         zero_q   <= 1'b0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         sel_q    <= sel_d;
         data1_q  <= data1_d;
         data2_q  <= data2_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
      end
   end

   assign gnt0_o       = gnt0_q;
   assign gnt1_o       = gnt1_q;
   assign done0_o      = done0_q;
   assign done1_o      = done1_q;
   assign result_out_o = result_q;
   assign zero_out_o   = zero_q;
   assign alu_data1_o  = data1_q;
   assign alu_data2_o  = data2_q;
   assign alu_select_o = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter with a scoreboard of
//               expected completions; honours ALU_ARB_ERR_CHECK_EN.
// Revision    : 1.0
// ============================================================================
module tb_alu_arbiter;

   localparam int unsigned WAIT = 2;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       req0_i, req1_i;
   logic [2:0] op0_i, op1_i;
   logic [7:0] a0_i, b0_i, a1_i, b1_i;
   logic       gnt0_o, gnt1_o, done0_o, done1_o;
   logic [7:0] result_out_o;
   logic       zero_out_o, err_o;
   logic [7:0] alu_data1_o, alu_data2_o;
   logic [2:0] alu_select_o;
   logic [7:0] alu_result_i;
   logic       alu_zero_i;

   typedef struct {
      logic       who;
      logic [7:0] res;
      logic       zero;
      logic       err;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_res  = 8'd0;
   logic       exp_zero = 1'b0;
   logic       d0, d1;
   int         cyc;

   function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return a;
         3'd1:    return a + b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a - b;
         3'd6:    return ~a;
         default: return b;
      endcase
   endfunction

   assign alu_result_i = alu_model(alu_select_o, alu_data1_o, alu_data2_o);
   assign alu_zero_i   = (alu_result_i == 8'd0);

   always #5 clk_i = ~clk_i;

   alu_arbiter #(.WAIT_CYCLES(WAIT)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .req0_i(req0_i), .req1_i(req1_i),
      .op0_i(op0_i), .op1_i(op1_i),
      .a0_i(a0_i), .b0_i(b0_i), .a1_i(a1_i), .b1_i(b1_i),
      .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
      .done0_o(done0_o), .done1_o(done1_o),
      .result_out_o(result_out_o), .zero_out_o(zero_out_o), .err_o(err_o),
      .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_select_o(alu_select_o),
      .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_exp(input logic who, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      exp_t x;
      x.who = who;
`ifdef ALU_ARB_ERR_CHECK_EN
      if (op[2]) begin
         x.res  = exp_res;
         x.zero = exp_zero;
         x.err  = 1'b1;
         sb.push_back(x);
         return;
      end
`endif
      x.res    = alu_model(op, a, b);
      x.zero   = (x.res == 8'd0);
      x.err    = 1'b0;
      exp_res  = x.res;
      exp_zero = x.zero;
      sb.push_back(x);
   endtask

   task automatic wait_done(output logic o0, output logic o1, output int n);
      o0 = 1'b0;
      o1 = 1'b0;
      n  = 0;
      while (n < 40 && !(o0 | o1)) begin
         tick();
         n++;
         o0 = done0_o;
         o1 = done1_o;
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b0;
      req0_i = 1'b1; req1_i = 1'b0;
      op0_i = 3'd0; a0_i = 8'd0; b0_i = 8'd0;
      op1_i = 3'd0; a1_i = 8'd0; b1_i = 8'd0;
      tick();
      tick();
      checks++;
      if ({gnt0_o, gnt1_o, done0_o, done1_o, err_o, zero_out_o, result_out_o,
           alu_data1_o, alu_data2_o, alu_select_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: gnt=%b%b done=%b%b err=%b zero=%b res=%h d1=%h d2=%h sel=%h, expected all 0",
                  gnt1_o, gnt0_o, done1_o, done0_o, err_o, zero_out_o, result_out_o,
                  alu_data1_o, alu_data2_o, alu_select_o);
      end
      push_exp(1'b0, op0_i, a0_i, b0_i);
      reset_i = 1'b1;
      tick();
      checks++;
      if ({gnt1_o, gnt0_o} !== 2'b01) begin
         errors++;
         $display("FAIL reset_first_gnt: gnt=%b expected 01", {gnt1_o, gnt0_o});
      end
      req0_i = 1'b0;
      wait_done(d0, d1, cyc);
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL reset_sb: scoreboard empty at completion");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({d1, d0} !== (e.who ? 2'b10 : 2'b01) || cyc != WAIT + 1) begin
            errors++;
            $display("FAIL reset_done: done=%b after %0d cycles, expected %b after %0d",
                     {d1, d0}, cyc, (e.who ? 2'b10 : 2'b01), WAIT + 1);
         end
         checks++;
         if ({result_out_o, zero_out_o, err_o} !== {e.res, e.zero, e.err}) begin
            errors++;
            $display("FAIL reset_result: res=%h zero=%b err=%b, expected res=%h zero=%b err=%b",
                     result_out_o, zero_out_o, err_o, e.res, e.zero, e.err);
         end
      end
   endtask

   task automatic test_single_op();
      op0_i = 3'd1; a0_i = 8'd3; b0_i = 8'd5;
      req0_i = 1'b1;
      push_exp(1'b0, op0_i, a0_i, b0_i);
      tick();
      checks++;
      if ({gnt1_o, gnt0_o} !== 2'b01 || {alu_select_o, alu_data1_o, alu_data2_o} !== {3'd1, 8'd3, 8'd5}) begin
         errors++;
         $display("FAIL single_gnt: gnt=%b sel=%h d1=%h d2=%h, expected gnt=01 sel=1 d1=03 d2=05",
                  {gnt1_o, gnt0_o}, alu_select_o, alu_data1_o, alu_data2_o);
      end
      req0_i = 1'b0;
      tick();
      checks++;
      if ({gnt1_o, gnt0_o} !== 2'b00) begin
         errors++;
         $display("FAIL single_gnt_pulse: gnt=%b one cycle after grant, expected 00", {gnt1_o, gnt0_o});
      end
      wait_done(d0, d1, cyc);
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL single_sb: scoreboard empty at completion");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({d1, d0} !== (e.who ? 2'b10 : 2'b01) || cyc + 1 != WAIT + 1) begin
            errors++;
            $display("FAIL single_done: done=%b after %0d cycles, expected %b after %0d",
                     {d1, d0}, cyc + 1, (e.who ? 2'b10 : 2'b01), WAIT + 1);
         end
         checks++;
         if ({result_out_o, zero_out_o, err_o} !== {e.res, e.zero, e.err}) begin
            errors++;
            $display("FAIL single_result: res=%h zero=%b err=%b, expected res=%h zero=%b err=%b",
                     result_out_o, zero_out_o, err_o, e.res, e.zero, e.err);
         end
      end
      tick();
      checks++;
      if ({done1_o, done0_o} !== 2'b00 || result_out_o !== 8'd8) begin
         errors++;
         $display("FAIL single_hold: done=%b res=%h after pulse, expected done=00 res=08",
                  {done1_o, done0_o}, result_out_o);
      end
   endtask

   task automatic test_zero_flag();
      op1_i = 3'd1; a1_i = 8'd1; b1_i = 8'hFF;
      req1_i = 1'b1;
      push_exp(1'b1, op1_i, a1_i, b1_i);
      tick();
      checks++;
      if ({gnt1_o, gnt0_o} !== 2'b10) begin
         errors++;
         $display("FAIL zero_gnt: gnt=%b expected 10", {gnt1_o, gnt0_o});
      end
      req1_i = 1'b0;
      wait_done(d0, d1, cyc);
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL zero_sb: scoreboard empty at completion");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({d1, d0} !== (e.who ? 2'b10 : 2'b01) || cyc != WAIT + 1) begin
            errors++;
            $display("FAIL zero_done: done=%b after %0d cycles, expected %b after %0d",
                     {d1, d0}, cyc, (e.who ? 2'b10 : 2'b01), WAIT + 1);
         end
         checks++;
         if ({result_out_o, zero_out_o, err_o} !== {e.res, e.zero, e.err}) begin
            errors++;
            $display("FAIL zero_result: res=%h zero=%b err=%b, expected res=%h zero=%b err=%b",
                     result_out_o, zero_out_o, err_o, e.res, e.zero, e.err);
         end
      end
   endtask

   task automatic test_contention();
      logic who;
      op0_i = 3'd2; a0_i = 8'hF0; b0_i = 8'h3C;
      op1_i = 3'd3; a1_i = 8'h01; b1_i = 8'h02;
      req0_i = 1'b1;
      req1_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         who = i[0];
         if (who) push_exp(1'b1, op1_i, a1_i, b1_i);
         else     push_exp(1'b0, op0_i, a0_i, b0_i);
         tick();
         checks++;
         if ({gnt1_o, gnt0_o} !== (who ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL contention_gnt%0d: gnt=%b expected %b", i, {gnt1_o, gnt0_o}, (who ? 2'b10 : 2'b01));
         end
         if (i == 2) begin
            req0_i = 1'b0;
            req1_i = 1'b0;
         end
         wait_done(d0, d1, cyc);
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL contention_sb%0d: scoreboard empty at completion", i);
         end else begin
            e = sb.pop_front();
            checks++;
            if ({d1, d0} !== (e.who ? 2'b10 : 2'b01) || cyc != WAIT + 1 || {gnt1_o, gnt0_o} !== 2'b00) begin
               errors++;
               $display("FAIL contention_done%0d: done=%b gnt=%b after %0d cycles, expected done=%b gnt=00 after %0d",
                        i, {d1, d0}, {gnt1_o, gnt0_o}, cyc, (e.who ? 2'b10 : 2'b01), WAIT + 1);
            end
            checks++;
            if ({result_out_o, zero_out_o, err_o} !== {e.res, e.zero, e.err}) begin
               errors++;
               $display("FAIL contention_result%0d: res=%h zero=%b err=%b, expected res=%h zero=%b err=%b",
                        i, result_out_o, zero_out_o, err_o, e.res, e.zero, e.err);
            end
         end
      end
   endtask

   task automatic test_busy_ignore();
      logic seen;
      op0_i = 3'd5; a0_i = 8'd10; b0_i = 8'd3;
      req0_i = 1'b1;
      push_exp(1'b0, op0_i, a0_i, b0_i);
      tick();
      checks++;
      if ({gnt1_o, gnt0_o} !== 2'b01) begin
         errors++;
         $display("FAIL busy_gnt: gnt=%b expected 01", {gnt1_o, gnt0_o});
      end
      req0_i = 1'b0;
      req1_i = 1'b1;
      tick();
      req1_i = 1'b0;
      tick();
      wait_done(d0, d1, cyc);
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL busy_sb: scoreboard empty at completion");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({d1, d0} !== (e.who ? 2'b10 : 2'b01) || cyc + 2 != WAIT + 1) begin
            errors++;
            $display("FAIL busy_done: done=%b after %0d cycles, expected %b after %0d",
                     {d1, d0}, cyc + 2, (e.who ? 2'b10 : 2'b01), WAIT + 1);
         end
         checks++;
         if ({result_out_o, zero_out_o, err_o} !== {e.res, e.zero, e.err}) begin
            errors++;
            $display("FAIL busy_result: res=%h zero=%b err=%b, expected res=%h zero=%b err=%b",
                     result_out_o, zero_out_o, err_o, e.res, e.zero, e.err);
         end
      end
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         seen = seen | gnt0_o | gnt1_o;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL busy_ignored: grant seen=%b for request dropped while busy, expected 0", seen);
      end
   endtask

   task automatic test_abort();
      op0_i = 3'd1; a0_i = 8'd10; b0_i = 8'd20;
      req0_i = 1'b1;
      tick();
      checks++;
      if ({gnt1_o, gnt0_o} !== 2'b01) begin
         errors++;
         $display("FAIL abort_gnt: gnt=%b expected 01", {gnt1_o, gnt0_o});
      end
      tick();
      reset_i = 1'b0;
      req1_i  = 1'b1;
      tick();
      exp_res  = 8'd0;
      exp_zero = 1'b0;
      checks++;
      if ({gnt0_o, gnt1_o, done0_o, done1_o, err_o, zero_out_o, result_out_o,
           alu_data1_o, alu_data2_o, alu_select_o} !== '0) begin
         errors++;
         $display("FAIL abort_outputs: gnt=%b%b done=%b%b err=%b zero=%b res=%h d1=%h d2=%h sel=%h, expected all 0",
                  gnt1_o, gnt0_o, done1_o, done0_o, err_o, zero_out_o, result_out_o,
                  alu_data1_o, alu_data2_o, alu_select_o);
      end
      tick();
      checks++;
      if ({done1_o, done0_o, gnt1_o, gnt0_o} !== 4'b0000) begin
         errors++;
         $display("FAIL abort_no_done: done=%b gnt=%b while held in reset, expected 00 00",
                  {done1_o, done0_o}, {gnt1_o, gnt0_o});
      end
      push_exp(1'b0, op0_i, a0_i, b0_i);
      reset_i = 1'b1;
      tick();
      checks++;
      if ({gnt1_o, gnt0_o} !== 2'b01) begin
         errors++;
         $display("FAIL abort_regrant: gnt=%b expected 01 (pointer back at requester 0)", {gnt1_o, gnt0_o});
      end
      req0_i = 1'b0;
      req1_i = 1'b0;
      wait_done(d0, d1, cyc);
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL abort_sb: scoreboard empty at completion");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({d1, d0} !== (e.who ? 2'b10 : 2'b01) || cyc != WAIT + 1) begin
            errors++;
            $display("FAIL abort_done: done=%b after %0d cycles, expected %b after %0d",
                     {d1, d0}, cyc, (e.who ? 2'b10 : 2'b01), WAIT + 1);
         end
         checks++;
         if ({result_out_o, zero_out_o, err_o} !== {e.res, e.zero, e.err}) begin
            errors++;
            $display("FAIL abort_result: res=%h zero=%b err=%b, expected res=%h zero=%b err=%b",
                     result_out_o, zero_out_o, err_o, e.res, e.zero, e.err);
         end
      end
   endtask

   task automatic test_illegal_op();
      logic [2:0] sel_exp;
      int         lat;
`ifdef ALU_ARB_ERR_CHECK_EN
      sel_exp = 3'd1;
      lat     = 1;
`else
      sel_exp = 3'd6;
      lat     = WAIT + 1;
`endif
      op0_i = 3'd6; a0_i = 8'h5A; b0_i = 8'h11;
      req0_i = 1'b1;
      push_exp(1'b0, op0_i, a0_i, b0_i);
      tick();
      checks++;
      if ({gnt1_o, gnt0_o} !== 2'b01 || alu_select_o !== sel_exp) begin
         errors++;
         $display("FAIL illegal_gnt: gnt=%b sel=%h, expected gnt=01 sel=%h", {gnt1_o, gnt0_o}, alu_select_o, sel_exp);
      end
      req0_i = 1'b0;
      wait_done(d0, d1, cyc);
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL illegal_sb: scoreboard empty at completion");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({d1, d0} !== (e.who ? 2'b10 : 2'b01) || cyc != lat) begin
            errors++;
            $display("FAIL illegal_done: done=%b after %0d cycles, expected %b after %0d",
                     {d1, d0}, cyc, (e.who ? 2'b10 : 2'b01), lat);
         end
         checks++;
         if ({result_out_o, zero_out_o, err_o} !== {e.res, e.zero, e.err}) begin
            errors++;
            $display("FAIL illegal_result: res=%h zero=%b err=%b, expected res=%h zero=%b err=%b",
                     result_out_o, zero_out_o, err_o, e.res, e.zero, e.err);
         end
      end
      tick();
      checks++;
      if (err_o !== 1'b0) begin
         errors++;
         $display("FAIL illegal_err_pulse: err=%b one cycle after completion, expected 0", err_o);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_op();
      test_zero_flag();
      test_contention();
      test_busy_ignore();
      test_abort();
      test_illegal_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: cycles between issuing operands to the alu and sampling ALU_RESULT/ALU_ZERO; legal range 1..15.
REQ-002 CLK  input  1  single system clock, all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-low reset, sampled on rising CLK.
REQ-004 REQ0, REQ1  input  1 each  request from requester 0 / 1.
REQ-005 OP0, OP1  input  3 each  ALU select code of requester 0 / 1.
REQ-006 A0, B0, A1, B1  input  8 each  operand DATA1/DATA2 of requester 0 / 1.
REQ-007 GNT0, GNT1  output  1 each  one-cycle grant pulse, operands captured.
REQ-008 DONE0, DONE1  output  1 each  one-cycle completion pulse to the served requester.
REQ-009 RESULT_OUT  output  8  registered result of the last completed operation.
REQ-010 ZERO_OUT  output  1  registered zero flag of the last completed operation.
REQ-011 ERR  output  1  one-cycle illegal-opcode flag, coincident with DONEx.
REQ-012 ALU_DATA1, ALU_DATA2  output  8 each  operands driven to the shared alu.
REQ-013 ALU_SELECT  output  3  select code driven to the alu.
REQ-014 ALU_RESULT  input  8 ; ALU_ZERO  input  1  alu result and zero flag.

Function
REQ-015 FSM states IDLE, BUSY, DONE; one transaction in flight at a time.
REQ-016 IDLE, any REQx high at an edge: winner chosen, OPx/Ax/Bx latched, GNTx high for the following cycle, state -> BUSY, wait counter loaded with WAIT_CYCLES.
REQ-017 ALU_DATA1/ALU_DATA2/ALU_SELECT driven from the latched registers, stable from the grant cycle until next grant; held at last value in IDLE.
REQ-018 BUSY: counter decrements each cycle; when counter reaches 1, next edge samples ALU_RESULT/ALU_ZERO into RESULT_OUT/ZERO_OUT and state -> DONE.
REQ-019 DONE: DONEx high for exactly one cycle to the served requester; next edge -> IDLE.
REQ-020 Latency: REQ sampled at edge E -> GNT high after E; DONE high after edge E+WAIT_CYCLES+1; RESULT_OUT valid with DONE and held until next completion.
REQ-021 Arbitration round-robin: priority pointer resets to requester 0; after each completion pointer points to the other requester.
REQ-022 Both REQ high in IDLE: pointer's requester wins; loser stays pending and is served next transaction if REQ still high.
REQ-023 REQ changes while BUSY/DONE ignored; REQ still high in IDLE after DONE starts a new transaction (requesters drop REQ on GNT).
REQ-024 GNT0/GNT1 and DONE0/DONE1 never high simultaneously; at most one transaction outstanding.

Reset
REQ-025 RESET low at an edge: state IDLE, pointer 0, counter 0, GNT0/1, DONE0/1, ERR, ZERO_OUT low, RESULT_OUT, ALU_DATA1, ALU_DATA2, ALU_SELECT all 0.
REQ-026 Reset mid-transaction aborts it: no DONE issued, no result captured; pending requests re-arbitrated after reset release.

Configuration
REQ-027 Macro ALU_ARB_ERR_CHECK_EN defined: OP 4..7 latched at grant skips BUSY, next edge -> DONE with DONEx and ERR high, RESULT_OUT/ZERO_OUT unchanged, ALU_SELECT not updated.
REQ-028 Macro undefined: ERR tied 0, every opcode issued to the alu and handled per REQ-016..REQ-019.

Verification
REQ-029 Reset: hold RESET low 2 cycles with REQ0=1 -> all outputs 0, no GNT until cycle after RESET high.
REQ-030 Single op: REQ0=1, OP0=1, A0=8'd3, B0=8'd5, WAIT_CYCLES=2 -> GNT0 one cycle, DONE0 3 edges after grant edge, RESULT_OUT=8'd8, ZERO_OUT=0.
REQ-031 Zero flag: REQ1=1, OP1=1, A1=8'd1, B1=8'hFF -> DONE1, RESULT_OUT=0, ZERO_OUT=1.
REQ-032 Contention: REQ0=REQ1=1 held, OP0=2 (AND 8'hF0,8'h3C), OP1=3 (OR 8'h01,8'h02) -> order GNT0,DONE0(8'h30),GNT1,DONE1(8'h03),GNT0...
REQ-033 Abort: assert RESET low in BUSY -> no DONE, outputs 0, REQ0 re-served after release.
REQ-034 With ALU_ARB_ERR_CHECK_EN: REQ0=1, OP0=3'd6 -> GNT0 then DONE0 with ERR=1 next cycle, RESULT_OUT unchanged; without macro ERR stays 0.
